// File: rtl/histogram_top.sv
// 3x3 binary median filter over a WIDTHxHEIGHT image with X/Y projection histograms.
// Optional feature macro HISTOGRAM_EN: bin storage, histogram stream and bin clear.
module histogram_top #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 180,
  parameter int ADDR_W = 8,
  parameter int HIST_W = 8,
  parameter int THRESH = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              filterDone,
  output logic              filterReady,
  input  logic              dataIn,
  output logic [ADDR_W-1:0] xAddressOut,
  output logic [ADDR_W-1:0] yAddressOut,
  output logic [ADDR_W-1:0] xMedianAddress,
  output logic [ADDR_W-1:0] yMedianAddress,
  output logic              writeEnable,
  output logic              dataOut,
  input  logic              readHistogram,
  input  logic              clearHistogram,
  output logic [HIST_W-1:0] xHistogramOut,
  output logic [HIST_W-1:0] yHistogramOut,
  output logic              xValid,
  output logic              yValid,
  output logic              histogramClear
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(HEIGHT - 1);
  localparam logic [ADDR_W:0]   X_MAX    = (ADDR_W+1)'(WIDTH - 1);
  localparam logic [ADDR_W:0]   Y_MAX    = (ADDR_W+1)'(HEIGHT - 1);
  localparam logic [3:0]        THRESH_C = 4'(THRESH);

  state_t            state;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] row;
  logic [2:0]        step;
  logic              priming;
  logic              last_write;
  logic [2:0]        win_top, win_mid, win_bot;
  logic              d0, d1;
  logic [ADDR_W:0]   rd_row;
  logic              row_ok;
  logic [3:0]        ones;
  logic              hist_open;

  // Source x for triplet slot k (0..2 -> x-1..x+1), clamped into the image.
  function automatic logic [ADDR_W-1:0] clamp_x(input logic [ADDR_W-1:0] c, input logic [1:0] k);
    logic [ADDR_W:0] t;
    t = {1'b0, c} + (ADDR_W+1)'(k);
    if (t == '0) return '0;
    t = t - (ADDR_W+1)'(1);
    if (t > X_MAX) return X_MAX[ADDR_W-1:0];
    return t[ADDR_W-1:0];
  endfunction

  function automatic logic [ADDR_W-1:0] clamp_y(input logic [ADDR_W:0] r);
    if (r > Y_MAX) return Y_MAX[ADDR_W-1:0];
    return r[ADDR_W-1:0];
  endfunction

  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 9; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    rd_row = priming ? '0 : ({1'b0, row} + (ADDR_W+1)'(1));
    row_ok = (rd_row <= Y_MAX);
    ones   = popcount9({win_top, win_mid, win_bot});
  end

  assign hist_open = (state != RUN);

  // Per output pixel: steps 0-2 present the triplet addresses, 1-3 capture data, 4 writes.
  // A priming triplet (row 0) runs steps 0-3 only and opens every column.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      filterReady    <= 1'b1;
      filterDone     <= 1'b0;
      writeEnable    <= 1'b0;
      dataOut        <= 1'b0;
      xAddressOut    <= '0;
      yAddressOut    <= '0;
      xMedianAddress <= '0;
      yMedianAddress <= '0;
      col            <= '0;
      row            <= '0;
      step           <= '0;
      priming        <= 1'b0;
      last_write     <= 1'b0;
      win_top        <= '0;
      win_mid        <= '0;
      win_bot        <= '0;
      d0             <= 1'b0;
      d1             <= 1'b0;
    end else begin
      writeEnable <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            filterReady <= 1'b0;
            col         <= '0;
            row         <= '0;
            step        <= '0;
            priming     <= 1'b1;
            last_write  <= 1'b0;
            win_top     <= '0;
            win_mid     <= '0;
            win_bot     <= '0;
            xAddressOut <= '0;
            yAddressOut <= '0;
          end
        end
        RUN: begin
          if (last_write) begin
            state      <= DONE;
            filterDone <= 1'b1;
            last_write <= 1'b0;
          end else begin
            case (step)
              3'd0: begin
                xAddressOut <= clamp_x(col, 2'd1);
                step        <= 3'd1;
              end
              3'd1: begin
                d0          <= dataIn & (col != '0) & row_ok;
                xAddressOut <= clamp_x(col, 2'd2);
                step        <= 3'd2;
              end
              3'd2: begin
                d1   <= dataIn & row_ok;
                step <= 3'd3;
              end
              3'd3: begin
                win_top <= win_mid;
                win_mid <= win_bot;
                win_bot <= {dataIn & (col != COL_LAST) & row_ok, d1, d0};
                if (priming) begin
                  priming     <= 1'b0;
                  step        <= 3'd0;
                  xAddressOut <= clamp_x(col, 2'd0);
                  yAddressOut <= clamp_y((ADDR_W+1)'(1));
                end else begin
                  step <= 3'd4;
                end
              end
              3'd4: begin
                writeEnable    <= 1'b1;
                dataOut        <= (ones >= THRESH_C);
                xMedianAddress <= col;
                yMedianAddress <= row;
                step           <= 3'd0;
                if (row == ROW_LAST) begin
                  if (col == COL_LAST) begin
                    last_write <= 1'b1;
                  end else begin
                    col         <= col + ADDR_W'(1);
                    row         <= '0;
                    priming     <= 1'b1;
                    win_top     <= '0;
                    win_mid     <= '0;
                    win_bot     <= '0;
                    xAddressOut <= clamp_x(col + ADDR_W'(1), 2'd0);
                    yAddressOut <= '0;
                  end
                end else begin
                  row         <= row + ADDR_W'(1);
                  xAddressOut <= clamp_x(col, 2'd0);
                  yAddressOut <= clamp_y({1'b0, row} + (ADDR_W+1)'(2));
                end
              end
              default: step <= 3'd0;
            endcase
          end
        end
        DONE: begin
          if (!start) begin
            state       <= IDLE;
            filterDone  <= 1'b0;
            filterReady <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HISTOGRAM_EN
  localparam int XI_W = $clog2(WIDTH);
  localparam int YI_W = $clog2(HEIGHT);
  localparam logic [ADDR_W:0] W_C = (ADDR_W+1)'(WIDTH);
  localparam logic [ADDR_W:0] H_C = (ADDR_W+1)'(HEIGHT);

  logic [HIST_W-1:0] xbin [WIDTH];
  logic [HIST_W-1:0] ybin [HEIGHT];
  logic              read_q;
  logic              streaming;
  logic              stream_go;
  logic              fetch;
  logic [ADDR_W:0]   s_idx;
  logic [ADDR_W:0]   fetch_idx;

  // A clear in the same cycle suppresses a new stream.
  always_comb begin
    stream_go = hist_open && !clearHistogram && readHistogram && !read_q && !streaming;
    fetch_idx = stream_go ? '0 : s_idx;
    fetch     = stream_go || (streaming && (s_idx < W_C));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the bins are flops with async reset because they must read 0 whenever reset is low.
      for (int i = 0; i < WIDTH; i++)  xbin[i] <= '0;
      for (int i = 0; i < HEIGHT; i++) ybin[i] <= '0;
      histogramClear <= 1'b0;
      read_q         <= 1'b0;
      streaming      <= 1'b0;
      s_idx          <= '0;
      xHistogramOut  <= '0;
      yHistogramOut  <= '0;
      xValid         <= 1'b0;
      yValid         <= 1'b0;
    end else begin
      histogramClear <= 1'b0;
      read_q         <= readHistogram;
      if (hist_open && clearHistogram) begin
        for (int i = 0; i < WIDTH; i++)  xbin[i] <= '0;
        for (int i = 0; i < HEIGHT; i++) ybin[i] <= '0;
        histogramClear <= 1'b1;
      end else if (writeEnable && dataOut) begin
        xbin[xMedianAddress[XI_W-1:0]] <= xbin[xMedianAddress[XI_W-1:0]] + HIST_W'(1);
        ybin[yMedianAddress[YI_W-1:0]] <= ybin[yMedianAddress[YI_W-1:0]] + HIST_W'(1);
      end
      if (fetch) begin
        streaming     <= 1'b1;
        s_idx         <= fetch_idx + (ADDR_W+1)'(1);
        xHistogramOut <= xbin[fetch_idx[XI_W-1:0]];
        xValid        <= 1'b1;
        if (fetch_idx < H_C) begin
          yHistogramOut <= ybin[fetch_idx[YI_W-1:0]];
          yValid        <= 1'b1;
        end else begin
          yHistogramOut <= '0;
          yValid        <= 1'b0;
        end
      end else begin
        streaming     <= 1'b0;
        xHistogramOut <= '0;
        yHistogramOut <= '0;
        xValid        <= 1'b0;
        yValid        <= 1'b0;
      end
    end
  end
`else
  logic unused_read;
  assign unused_read = readHistogram;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) histogramClear <= 1'b0;
    else        histogramClear <= hist_open && clearHistogram;
  end

  assign xHistogramOut = '0;
  assign yHistogramOut = '0;
  assign xValid        = 1'b0;
  assign yValid        = 1'b0;
`endif

endmodule

// File: tb/tb_histogram_top.sv
// Scoreboard bench for histogram_top on a reduced image: a zero-padded 3x3 majority model
// feeds expected writes and bins into queues that a negedge monitor pops and compares.
module tb_histogram_top;
  localparam int W      = 20;
  localparam int H      = 14;
  localparam int AW     = 8;
  localparam int HW     = 8;
  localparam int TH     = 5;
  localparam int BUDGET = W * (8 + 5 * H) + 4;
`ifdef HISTOGRAM_EN
  localparam int HIST = 1;
`else
  localparam int HIST = 0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, readHistogram, clearHistogram;
  logic          dataIn = 1'b0;
  logic          filterDone, filterReady, writeEnable, dataOut;
  logic          xValid, yValid, histogramClear;
  logic [AW-1:0] xAddressOut, yAddressOut, xMedianAddress, yMedianAddress;
  logic [HW-1:0] xHistogramOut, yHistogramOut;

  always #5 clk = ~clk;

  histogram_top #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .HIST_W(HW), .THRESH(TH)) dut (
    .clk(clk), .reset(reset), .start(start), .filterDone(filterDone), .filterReady(filterReady),
    .dataIn(dataIn), .xAddressOut(xAddressOut), .yAddressOut(yAddressOut),
    .xMedianAddress(xMedianAddress), .yMedianAddress(yMedianAddress),
    .writeEnable(writeEnable), .dataOut(dataOut), .readHistogram(readHistogram),
    .clearHistogram(clearHistogram), .xHistogramOut(xHistogramOut), .yHistogramOut(yHistogramOut),
    .xValid(xValid), .yValid(yValid), .histogramClear(histogramClear)
  );

  typedef struct { int x; int y; int v; } wr_t;
  typedef struct { int idx; int xv; int yv; int yon; } bin_t;

  wr_t  wr_q[$];
  bin_t bin_q[$];
  bit   src [W][H];
  int   mx [W];
  int   my [H];
  int   got_x [W];
  int   got_y [H];
  int   passed = 0, total = 0;
  int   writes_seen = 0, xv_cnt = 0, yv_cnt = 0;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  // Source memory: one-cycle read latency.
  always @(posedge clk) begin
    int xa, ya;
    xa = int'(xAddressOut);
    ya = int'(yAddressOut);
    dataIn <= (xa < W && ya < H) ? src[xa][ya] : 1'b0;
  end

  always @(negedge clk) begin
    wr_t  e;
    bin_t b;
    if (writeEnable) begin
      writes_seen++;
      if (wr_q.size() == 0) check("extra_write", 1, 0);
      else begin
        e = wr_q.pop_front();
        check($sformatf("wr_addr(%0d,%0d)", e.x, e.y),
              int'(xMedianAddress) * 256 + int'(yMedianAddress), e.x * 256 + e.y);
        check($sformatf("wr_data(%0d,%0d)", e.x, e.y), int'(dataOut), e.v);
      end
    end
    if (yValid) yv_cnt++;
    if (xValid) begin
      xv_cnt++;
      if (bin_q.size() == 0) check("extra_xvalid", 1, 0);
      else begin
        b = bin_q.pop_front();
        got_x[b.idx] = int'(xHistogramOut);
        check($sformatf("xbin[%0d]", b.idx), int'(xHistogramOut), b.xv);
        check($sformatf("yvalid[%0d]", b.idx), int'(yValid), b.yon);
        if (b.yon != 0) begin
          got_y[b.idx] = int'(yHistogramOut);
          check($sformatf("ybin[%0d]", b.idx), int'(yHistogramOut), b.yv);
        end
      end
    end
  end

  task automatic build_image(input int kind);
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        case (kind)
          0: src[x][y] = 1'b0;
          1: src[x][y] = 1'b1;
          2: src[x][y] = (x == 10 && y == 10);
          default: src[x][y] = ($urandom_range(0, 99) < 50);
        endcase
  endtask

  // Expected writes in scan order; optionally fold the result into the model bins.
  task automatic queue_pass(input bit accumulate);
    wr_t e;
    int  cnt;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++) begin
        cnt = 0;
        for (int dx = -1; dx <= 1; dx++)
          for (int dy = -1; dy <= 1; dy++)
            if (x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
              cnt += int'(src[x + dx][y + dy]);
        e.x = x; e.y = y; e.v = (cnt >= TH) ? 1 : 0;
        wr_q.push_back(e);
        if (accumulate && e.v != 0) begin
          mx[x]++;
          my[y]++;
        end
      end
  endtask

  task automatic zero_model();
    for (int i = 0; i < W; i++) mx[i] = 0;
    for (int i = 0; i < H; i++) my[i] = 0;
  endtask

  task automatic run_pass(input string tag);
    int cyc;
    writes_seen = 0;
    queue_pass(1'b1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check({tag, "_ready_low"}, int'(filterReady), 0);
    cyc = 1;
    while (!filterDone && cyc < BUDGET + 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done"}, int'(filterDone), 1);
    check({tag, "_cycles_in_budget"}, int'(cyc <= BUDGET), 1);
    check({tag, "_write_count"}, writes_seen, W * H);
    check({tag, "_writes_pending"}, wr_q.size(), 0);
    wr_q.delete();
    start = 1'b0;
    @(negedge clk);
    check({tag, "_ready_again"}, int'(filterReady), 1);
    check({tag, "_done_low"}, int'(filterDone), 0);
  endtask

  task automatic read_stream(input string tag);
    bin_t b;
    xv_cnt = 0;
    yv_cnt = 0;
    bin_q.delete();
    if (HIST != 0)
      for (int i = 0; i < W; i++) begin
        b.idx = i; b.xv = mx[i];
        b.yon = (i < H) ? 1 : 0;
        b.yv  = (i < H) ? my[i] : 0;
        bin_q.push_back(b);
      end
    @(negedge clk);
    readHistogram = 1'b1;
    @(negedge clk);
    check({tag, "_first_valid"}, int'(xValid), HIST);
    repeat (W + 4) @(negedge clk);
    readHistogram = 1'b0;
    check({tag, "_xvalid_cycles"}, xv_cnt, HIST * W);
    check({tag, "_yvalid_cycles"}, yv_cnt, HIST * H);
    check({tag, "_bins_pending"}, bin_q.size(), 0);
    bin_q.delete();
  endtask

  task automatic clear_bins(input string tag, input bit with_read);
    xv_cnt = 0;
    bin_q.delete();
    @(negedge clk);
    clearHistogram = 1'b1;
    if (with_read) readHistogram = 1'b1;
    @(negedge clk);
    clearHistogram = 1'b0;
    check({tag, "_pulse"}, int'(histogramClear), 1);
    @(negedge clk);
    check({tag, "_pulse_end"}, int'(histogramClear), 0);
    zero_model();
    if (with_read) begin
      repeat (W + 2) @(negedge clk);
      readHistogram = 1'b0;
      check({tag, "_read_dropped"}, xv_cnt, 0);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; readHistogram = 1'b0; clearHistogram = 1'b0;
    zero_model();
    #23;
    check("rst_ready", int'(filterReady), 1);
    check("rst_done", int'(filterDone), 0);
    check("rst_we", int'(writeEnable), 0);
    check("rst_xaddr", int'(xAddressOut), 0);
    check("rst_xvalid", int'(xValid), 0);
    check("rst_clear", int'(histogramClear), 0);
    check("rst_xhist", int'(xHistogramOut), 0);
    @(negedge clk);
    reset = 1'b1;

    build_image(0); run_pass("zeros"); read_stream("zeros_bins");
    build_image(1); run_pass("ones");  read_stream("ones_bins");
`ifdef HISTOGRAM_EN
    check("ones_xbin_edge", got_x[0], H - 2);
    check("ones_xbin_mid", got_x[W / 2], H);
    check("ones_ybin_edge", got_y[0], W - 2);
    check("ones_ybin_mid", got_y[H / 2], W);
`endif
    build_image(2); run_pass("single");
    build_image(3); run_pass("random"); read_stream("accum_bins");
    clear_bins("clear", 1'b0);          read_stream("cleared_bins");
    clear_bins("clear_wins", 1'b1);

    // Abort a pass with reset, then rerun the same image from scratch.
    build_image(3);
    queue_pass(1'b0);
    @(negedge clk);
    start = 1'b1;
    repeat (W * H * 2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_ready", int'(filterReady), 1);
    check("abort_done", int'(filterDone), 0);
    check("abort_we", int'(writeEnable), 0);
    check("abort_xaddr", int'(xAddressOut), 0);
    check("abort_wr_x", int'(xMedianAddress), 0);
    check("abort_dout", int'(dataOut), 0);
    wr_q.delete();
    start = 1'b0;
    zero_model();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_pass("restart"); read_stream("restart_bins");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
